// File: rtl/vga_pkg.sv
// Shared screen geometry, port widths and arbiter state encoding for the VGA plotting path.
package vga_pkg;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef enum logic [1:0] {
    StIdle,
    StSpan,
    StClear
  } state_e;

  localparam logic [2:0] BLACK = 3'b000;
endpackage

// File: rtl/vga_rr_grant.sv
// Combinational round-robin arbiter: one-hot grant to the first valid requester at or after i_ptr.
module vga_rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((32'(i_ptr) + 32'(k)) % NUM_REQ);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Sole driver of the VGA adapter write port: round-robin vertical-span requesters plus a
// full-screen clear engine, one pixel per clock through a registered output stage.
module vga_plot_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned X_W      = vga_pkg::X_W,
  parameter int unsigned Y_W      = vga_pkg::Y_W,
  parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
  parameter int unsigned X_MAX    = vga_pkg::SCREEN_W - 1,
  parameter int unsigned Y_MAX    = vga_pkg::SCREEN_H - 1
) (
  input  logic                          i_clock,
  input  logic                          i_resetn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*X_W-1:0]        i_req_x,
  input  logic [NUM_REQ*Y_W-1:0]        i_req_y0,
  input  logic [NUM_REQ*Y_W-1:0]        i_req_y1,
  input  logic [NUM_REQ*COLOUR_W-1:0]   i_req_colour,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_done,
  input  logic                          i_clear_req,
  input  logic [COLOUR_W-1:0]           i_clear_colour,
  output logic                          o_busy,
  output logic [X_W-1:0]                o_x,
  output logic [Y_W-1:0]                o_y,
  output logic [COLOUR_W-1:0]           o_colour,
  output logic                          o_plot
);
  import vga_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_clear_pending;
  logic [NUM_REQ-1:0]    r_cur;
  logic [Y_W-1:0]        r_yhi;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [COLOUR_W-1:0]   r_colour;
  logic                  r_plot;
  logic [NUM_REQ-1:0]    r_done;

  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_clear;
  logic                  w_idle;
  logic [X_W-1:0]        w_sel_x;
  logic [Y_W-1:0]        w_sel_y0;
  logic [Y_W-1:0]        w_sel_y1;
  logic [COLOUR_W-1:0]   w_sel_colour;
  logic [Y_W-1:0]        w_ylo;
  logic [Y_W-1:0]        w_ymax;
  logic [Y_W-1:0]        w_yhi;
  logic                  w_empty;

  vga_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .i_valid (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A clear_req arriving in the IDLE decision cycle itself must already beat the requesters.
  assign w_clear = r_clear_pending | i_clear_req;
  assign w_idle  = (r_state == StIdle);

  assign w_sel_x      = i_req_x[w_idx*X_W +: X_W];
  assign w_sel_y0     = i_req_y0[w_idx*Y_W +: Y_W];
  assign w_sel_y1     = i_req_y1[w_idx*Y_W +: Y_W];
  assign w_sel_colour = i_req_colour[w_idx*COLOUR_W +: COLOUR_W];
  assign w_ylo        = (w_sel_y0 < w_sel_y1) ? w_sel_y0 : w_sel_y1;
  assign w_ymax       = (w_sel_y0 < w_sel_y1) ? w_sel_y1 : w_sel_y0;
  assign w_yhi        = (w_ymax > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : w_ymax;
  assign w_empty      = (w_sel_x > X_W'(X_MAX)) || (w_ylo > Y_W'(Y_MAX));

  // Gated by reset so a held request is never acknowledged while the block is held in reset.
  assign o_req_ready = (w_idle && !w_clear && i_resetn) ? w_grant : '0;
  assign o_busy      = !w_idle || r_clear_pending;
  assign o_done      = r_done;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_colour    = r_colour;
  assign o_plot      = r_plot;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state         <= StIdle;
      r_rr_ptr        <= '0;
      r_clear_pending <= 1'b0;
      r_cur           <= '0;
      r_yhi           <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_colour        <= COLOUR_W'(BLACK);
      r_plot          <= 1'b0;
      r_done          <= '0;
    end else begin
      if (w_idle && w_clear) begin
        r_clear_pending <= 1'b0;
      end else if (i_clear_req) begin
        r_clear_pending <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          r_plot <= 1'b0;
          r_done <= '0;
          if (w_clear) begin
            r_state  <= StClear;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= i_clear_colour;
            r_plot   <= 1'b1;
          end else if (w_any) begin
            r_state  <= StSpan;
            r_cur    <= w_grant;
            r_yhi    <= w_yhi;
            r_rr_ptr <= PTR_W'((32'(w_idx) + 32'd1) % NUM_REQ);
            if (w_empty) begin
              r_done <= w_grant;
            end else begin
              r_x      <= w_sel_x;
              r_y      <= w_ylo;
              r_colour <= w_sel_colour;
              r_plot   <= 1'b1;
              if (w_ylo == w_yhi) r_done <= w_grant;
            end
          end
        end
        StSpan: begin
          // r_done set means the pixel now on the port is the span's last one.
          if (|r_done) begin
            r_state <= StIdle;
            r_plot  <= 1'b0;
            r_done  <= '0;
          end else begin
            r_y    <= r_y + 1'b1;
            r_done <= ((r_y + 1'b1) == r_yhi) ? r_cur : '0;
          end
        end
        StClear: begin
          if (r_x == X_W'(X_MAX) && r_y == Y_W'(Y_MAX)) begin
            r_state <= StIdle;
            r_plot  <= 1'b0;
          end else if (r_x == X_W'(X_MAX)) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, spans, round-robin, clipping, clear and mid-span reset.
module tb_vga_plot_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [15:0] req_x;
  logic [13:0] req_y0;
  logic [13:0] req_y1;
  logic [5:0]  req_colour;
  logic [1:0]  req_ready;
  logic [1:0]  done;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  int n_total = 0;
  int n_pass  = 0;
  int n_bad   = 0;

  vga_plot_arbiter dut (
    .i_clock        (clk),
    .i_resetn       (resetn),
    .i_req_valid    (req_valid),
    .i_req_x        (req_x),
    .i_req_y0       (req_y0),
    .i_req_y1       (req_y1),
    .i_req_colour   (req_colour),
    .o_req_ready    (req_ready),
    .o_done         (done),
    .i_clear_req    (clear_req),
    .i_clear_colour (clear_colour),
    .o_busy         (busy),
    .o_x            (x),
    .o_y            (y),
    .o_colour       (colour),
    .o_plot         (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int rx, input int ry0, input int ry1, input int rc);
    req_x[i*8 +: 8]      = 8'(rx);
    req_y0[i*7 +: 7]     = 7'(ry0);
    req_y1[i*7 +: 7]     = 7'(ry1);
    req_colour[i*3 +: 3] = 3'(rc);
    req_valid[i]         = 1'b1;
  endtask

  // Issues one span from an IDLE cycle and follows it to the next IDLE cycle.
  task automatic run_span(input int i, input int rx, input int ry0, input int ry1, input int rc,
                          input int exp_ylo, input int exp_n, input string tag);
    set_req(i, rx, ry0, ry1, rc);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
    if (exp_n == 0) begin
      tick();
      req_valid[i] = 1'b0;
      #1;
      check({tag, "_empty_plot"}, 32'(plot), 32'd0);
      check({tag, "_empty_done"}, 32'(done), 32'(1 << i));
    end else begin
      for (int k = 0; k < exp_n; k++) begin
        tick();
        if (k == 0) req_valid[i] = 1'b0;
        #1;
        check({tag, "_plot"}, 32'(plot), 32'd1);
        check({tag, "_x"}, 32'(x), 32'(rx));
        check({tag, "_y"}, 32'(y), 32'(exp_ylo + k));
        check({tag, "_colour"}, 32'(colour), 32'(rc));
        check({tag, "_done"}, 32'(done), (k == exp_n - 1) ? 32'(1 << i) : 32'd0);
      end
    end
    tick();
    #1;
    check({tag, "_idle_plot"}, 32'(plot), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetn       = 1'b0;
    req_valid    = '0;
    req_x        = '0;
    req_y0       = '0;
    req_y1       = '0;
    req_colour   = '0;
    clear_req    = 1'b0;
    clear_colour = 3'd0;

    // Reset state, and a request under reset is not acknowledged.
    repeat (3) tick();
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    set_req(0, 10, 20, 23, 4);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    resetn    = 1'b1;
    #1;

    run_span(0, 10, 20, 23, 4, 20, 4, "basic");

    // Fresh reset so the round-robin pointer restarts at requester 0.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    #1;
    set_req(0, 30, 5, 6, 2);
    set_req(1, 40, 8, 9, 3);
    #1;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % 2;
      check("rr_ready", 32'(req_ready), 32'(1 << e));
      check("rr_bubble", 32'(plot), 32'd0);
      tick();
      check("rr_px0_plot", 32'(plot), 32'd1);
      check("rr_px0_x", 32'(x), (e == 0) ? 32'd30 : 32'd40);
      check("rr_px0_y", 32'(y), (e == 0) ? 32'd5 : 32'd8);
      check("rr_px0_ready", 32'(req_ready), 32'd0);
      tick();
      check("rr_px1_y", 32'(y), (e == 0) ? 32'd6 : 32'd9);
      check("rr_px1_done", 32'(done), 32'(1 << e));
      tick();
      if (g == 3) req_valid = '0;
      #1;
    end
    check("rr_end_ready", 32'(req_ready), 32'd0);
    check("rr_end_plot", 32'(plot), 32'd0);

    run_span(0, 12, 50, 47, 5, 47, 4, "swap");
    run_span(1, 60, 117, 125, 6, 117, 3, "clip");
    run_span(0, 170, 10, 12, 2, 0, 0, "xoff");
    check("xoff_hold_x", 32'(x), 32'd60);
    check("xoff_hold_y", 32'(y), 32'd119);

    // Clear pulsed mid-span; requester 1 waits through the whole clear.
    set_req(0, 20, 0, 5, 7);
    #1;
    check("clr_span_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 100, 30, 30, 6);
    clear_colour = 3'b001;
    #1;
    check("clr_span_y0", 32'(y), 32'd0);
    tick();
    clear_req = 1'b1;
    #1;
    check("clr_span_y1", 32'(y), 32'd1);
    tick();
    clear_req = 1'b0;
    #1;
    check("clr_span_y2", 32'(y), 32'd2);
    check("clr_pending_busy", 32'(busy), 32'd1);
    for (int k = 3; k < 6; k++) begin
      tick();
      check("clr_span_y", 32'(y), 32'(k));
      check("clr_span_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    check("clr_decide_plot", 32'(plot), 32'd0);
    check("clr_decide_ready", 32'(req_ready), 32'd0);
    check("clr_decide_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 19200; c++) begin
      tick();
      if ({plot, colour, x, y, req_ready, done} !==
          {1'b1, 3'b001, 8'(c % 160), 7'(c / 160), 2'b00, 2'b00}) n_bad++;
      if (c == 0) begin
        check("clr_first_x", 32'(x), 32'd0);
        check("clr_first_y", 32'(y), 32'd0);
      end
      if (c == 19199) begin
        check("clr_last_x", 32'(x), 32'd159);
        check("clr_last_y", 32'(y), 32'd119);
      end
    end
    check("clr_scan_bad_cycles", 32'(n_bad), 32'd0);
    tick();
    check("clr_end_plot", 32'(plot), 32'd0);
    check("clr_end_ready", 32'(req_ready), 32'd2);
    check("clr_end_hold_x", 32'(x), 32'd159);
    check("clr_end_busy", 32'(busy), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    #1;
    check("post_clr_x", 32'(x), 32'd100);
    check("post_clr_y", 32'(y), 32'd30);
    check("post_clr_colour", 32'(colour), 32'd6);
    check("post_clr_done", 32'(done), 32'd2);
    tick();
    check("post_clr_idle", 32'(plot), 32'd0);

    // Reset during the second pixel of a 10-pixel span, then re-grant.
    set_req(0, 5, 40, 49, 3);
    #1;
    check("mrst_ready", 32'(req_ready), 32'd1);
    tick();
    check("mrst_px0_y", 32'(y), 32'd40);
    tick();
    check("mrst_px1_y", 32'(y), 32'd41);
    resetn = 1'b0;
    #1;
    check("mrst_plot", 32'(plot), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_x", 32'(x), 32'd0);
    check("mrst_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("mrst_held_plot", 32'(plot), 32'd0);
    check("mrst_held_done", 32'(done), 32'd0);
    resetn = 1'b1;
    #1;
    check("mrst_regrant", 32'(req_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) req_valid[0] = 1'b0;
      #1;
      check("mrst_plot_on", 32'(plot), 32'd1);
      check("mrst_y", 32'(y), 32'(40 + k));
      check("mrst_span_done", 32'(done), (k == 9) ? 32'd1 : 32'd0);
    end
    tick();
    check("mrst_end_plot", 32'(plot), 32'd0);
    check("mrst_end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
